// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per handshake as start, LSB-first data,
// optional parity and stop, each bit held for Prescale clock cycles.
module uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state, state_nxt;
    logic [PRESCALE_WIDTH-1:0] cyc_cnt, cyc_cnt_nxt;
    logic [BIT_CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic [PRESCALE_WIDTH-1:0] eff_ps;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      par_q;
    logic                      pe_q;
    logic                      accept;
    logic                      bit_end;
    logic                      tx_nxt;
    logic                      busy_nxt;
    logic [DATA_WIDTH-1:0]     data_shift;

    assign accept  = (state == IDLE) && Data_Valid;
    assign bit_end = (cyc_cnt == eff_ps - PRESCALE_WIDTH'(1));

    always_comb begin
        state_nxt   = state;
        cyc_cnt_nxt = bit_end ? '0 : cyc_cnt + PRESCALE_WIDTH'(1);
        bit_cnt_nxt = bit_cnt;
        case (state)
            IDLE: begin
                cyc_cnt_nxt = '0;
                if (accept) begin
                    state_nxt   = START;
                    bit_cnt_nxt = '0;
                end
            end
            START: begin
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == LAST_BIT) state_nxt = pe_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Line level is decoded from the next state so TX_OUT and busy leave flops directly
        data_shift = data_q >> bit_cnt_nxt;
        busy_nxt   = (state_nxt != IDLE);
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = data_shift[0];
            PARITY:  tx_nxt = par_q;
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            TX_OUT  <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            TX_OUT  <= tx_nxt;
            busy    <= busy_nxt;
        end
    end

    // Frame configuration is captured once per acceptance and ignored mid-frame
    always_ff @(posedge CLK) begin
        if (accept) begin
            data_q <= P_DATA;
            pe_q   <= parity_enable;
            par_q  <= (^P_DATA) ^ parity_type;
            eff_ps <= (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: per-cycle line/busy model plus a mid-bit frame decoder.
module tb_uart_tx;

    localparam int DW = 8;
    localparam int PW = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic [PW-1:0] Prescale;
    logic          parity_enable;
    logic          parity_type;
    logic          TX_OUT;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .Prescale     (Prescale),
        .parity_enable(parity_enable),
        .parity_type  (parity_type),
        .TX_OUT       (TX_OUT),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level for frame bit position b (0 = start)
    function automatic logic model_bit(input logic [DW-1:0] d, input bit pe, input bit pt, input int b);
        int ones;
        ones = 0;
        for (int i = 0; i < DW; i++) ones += d[i];
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
        if (pe && b == DW + 1) return ((ones % 2) == 1) ^ pt;
        return 1'b1;
    endfunction

    // Starts on a negedge with the DUT idle; returns on the idle negedge after the frame
    task automatic run_frame(input logic [DW-1:0] d, input bit pe, input bit pt,
                             input logic [PW-1:0] ps, input bit noise, input bit hold);
        int   eff;
        int   nb;
        int   total;
        int   busy_cnt;
        logic samples[$];
        logic [DW-1:0] rx;
        logic par_bit;
        eff      = (ps == 0) ? 1 : int'(ps);
        nb       = DW + 2 + (pe ? 1 : 0);
        total    = nb * eff;
        busy_cnt = 0;
        P_DATA        = d;
        parity_enable = pe;
        parity_type   = pt;
        Prescale      = ps;
        Data_Valid    = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < total; k++) begin
            check_eq("tx_line", TX_OUT, model_bit(d, pe, pt, k / eff));
            check_eq("busy_hi", busy, 1'b1);
            if (busy) busy_cnt++;
            samples.push_back(TX_OUT);
            if (!hold) Data_Valid = 1'b0;
            if (noise) begin
                P_DATA        = DW'($urandom);
                Prescale      = PW'($urandom);
                parity_enable = 1'($urandom);
                parity_type   = 1'($urandom);
                if (!hold) Data_Valid = ($urandom_range(0, 3) == 0);
                if (k == 20) begin
                    P_DATA     = 8'h55;
                    Data_Valid = 1'b1;
                end
            end
            @(negedge CLK);
        end
        check_eq("idle_tx", TX_OUT, 1'b1);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("busy_len", busy_cnt, total);
        for (int i = 0; i < DW; i++) rx[i] = samples[(i + 1) * eff + eff / 2];
        check_eq("rx_start", samples[eff / 2], 1'b0);
        check_eq("rx_data", rx, d);
        if (pe) begin
            par_bit = samples[(DW + 1) * eff + eff / 2];
            check_eq("rx_par", par_bit ^ (^rx), pt);
        end
        check_eq("rx_stop", samples[(nb - 1) * eff + eff / 2], 1'b1);
        if (!hold) Data_Valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check_eq("gap_tx", TX_OUT, 1'b1);
            check_eq("gap_busy", busy, 1'b0);
        end
    endtask

    initial begin
        RST           = 1'b1;
        Data_Valid    = 1'b0;
        P_DATA        = '0;
        Prescale      = 5'd8;
        parity_enable = 1'b0;
        parity_type   = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("rst_tx", TX_OUT, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        RST = 1'b0;
        idle_cycles(2);

        run_frame(8'hA5, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0);
        idle_cycles(2);
        run_frame(8'hA5, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
        idle_cycles(1);
        run_frame(8'h3C, 1'b0, 1'b0, 5'd16, 1'b0, 1'b0);
        idle_cycles(1);
        run_frame(8'h01, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1);
        run_frame(8'hFF, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0);
        idle_cycles(1);
        run_frame(8'hA5, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
        idle_cycles(2);

        // Abort a frame in its data phase with an asynchronous reset
        P_DATA        = 8'hA5;
        parity_enable = 1'b1;
        parity_type   = 1'b0;
        Prescale      = 5'd8;
        Data_Valid    = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (27) @(negedge CLK);
        check_eq("pre_rst_busy", busy, 1'b1);
        #2 RST = 1'b1;
        #1;
        check_eq("async_rst_tx", TX_OUT, 1'b1);
        check_eq("async_rst_busy", busy, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        idle_cycles(3);
        run_frame(8'h81, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
        idle_cycles(1);

        run_frame(8'h5A, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0);
        idle_cycles(1);
        run_frame(8'hC3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        idle_cycles(1);

        for (int i = 0; i < 25; i++) begin
            logic [DW-1:0] d;
            bit            pe, pt, noise, hold;
            logic [PW-1:0] ps;
            d     = DW'($urandom);
            pe    = 1'($urandom);
            pt    = 1'($urandom);
            ps    = PW'($urandom);
            noise = 1'($urandom);
            hold  = (i < 24) ? 1'($urandom) : 1'b0;
            run_frame(d, pe, pt, ps, noise, hold);
            if (!hold) idle_cycles($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
